execute_load_align_pipe: RTL and testbench

//  Parametrised, registered load-data alignment stage between the data-memory return path and writeback.

---
 rtl/execute_load_pkg.sv | 65 ++++++
 rtl/execute_load_extract.sv | 18 +
 rtl/execute_load_align_pipe.sv | 89 ++++++++
 tb/tb_execute_load_align_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_load_pkg.sv
// rtl/execute_load_pkg.sv - shared types and lane legality/extraction helpers for the load align stage
package execute_load_pkg;

  localparam int LD_BYTE_W    = 8;
  localparam int LD_MAX_W     = 64;
  localparam int LD_MAX_LANES = LD_MAX_W / LD_BYTE_W;

  function automatic int func_load_lanes(input int data_w);
    return data_w / LD_BYTE_W;
  endfunction

  typedef struct packed {
    logic [LD_MAX_LANES-1:0] mask;
    logic                    is_signed;
    logic [15:0]             tag;
    logic [LD_MAX_W-1:0]     data;
  } load_req_t;

  // Legal: 2^k contiguous lanes starting on a multiple of 2^k, within the first `lanes` lanes.
  function automatic logic func_load_mask_legal(input logic [LD_MAX_LANES-1:0] mask, input int lanes);
    logic ok;
    ok = 1'b0;
    for (int s = 1; s <= LD_MAX_LANES; s = s * 2) begin
      for (int st = 0; st < LD_MAX_LANES; st = st + s) begin
        if ((s <= lanes) && (st + s <= lanes) && (mask == LD_MAX_LANES'(((1 << s) - 1) << st)))
          ok = 1'b1;
      end
    end
    return ok;
  endfunction

  // Lane 0 is the most significant byte, so the lowest set mask bit is the field's top byte.
  function automatic logic [LD_MAX_W-1:0] func_load_extract(input logic [LD_MAX_LANES-1:0] mask,
                                                            input logic is_signed,
                                                            input logic [LD_MAX_W-1:0] data,
                                                            input int lanes);
    int                  start;
    int                  count;
    logic [LD_MAX_W-1:0] shifted;
    logic [LD_MAX_W-1:0] keep;
    logic [LD_MAX_W-1:0] res;
    start = 0;
    count = 0;
    for (int i = LD_MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        start = i;
        count = count + 1;
      end
    end
    res = '0;
    if (!func_load_mask_legal(mask, lanes)) begin
      res = '0;
    end else if (count >= lanes) begin
      res = data;
    end else begin
      shifted = data >> ((lanes - start - count) * LD_BYTE_W);
      keep    = (LD_MAX_W'(1) << (count * LD_BYTE_W)) - LD_MAX_W'(1);
      res     = shifted & keep;
      if (is_signed && shifted[6'(count * LD_BYTE_W - 1)])
        res = res | ~keep;
    end
    return res;
  endfunction

endpackage

// File: rtl/execute_load_extract.sv
// rtl/execute_load_extract.sv - combinational lane extract, extend and illegal-mask fault
module execute_load_extract
  import execute_load_pkg::*;
#(
  parameter  int P_DATA_W = 32,
  localparam int P_LANES  = P_DATA_W / 8
) (
  input  logic [P_LANES-1:0]  mask,
  input  logic                is_signed,
  input  logic [P_DATA_W-1:0] data,
  output logic [P_DATA_W-1:0] result,
  output logic                fault
);

  assign fault  = ~func_load_mask_legal(LD_MAX_LANES'(mask), P_LANES);
  assign result = P_DATA_W'(func_load_extract(LD_MAX_LANES'(mask), is_signed, LD_MAX_W'(data), P_LANES));

endmodule

// File: rtl/execute_load_align_pipe.sv
// rtl/execute_load_align_pipe.sv - registered load align stage with output + skid buffer
module execute_load_align_pipe
  import execute_load_pkg::*;
#(
  parameter  int P_DATA_W = 32,
  parameter  int P_TAG_W  = 5,
  localparam int P_LANES  = P_DATA_W / 8
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iFLUSH,
  input  logic                iPREV_VALID,
  output logic                oPREV_LOCK,
  input  logic [P_LANES-1:0]  iPREV_MASK,
  input  logic                iPREV_SIGNED,
  input  logic [P_TAG_W-1:0]  iPREV_TAG,
  input  logic [P_DATA_W-1:0] iPREV_DATA,
  output logic                oNEXT_VALID,
  input  logic                iNEXT_LOCK,
  output logic [P_DATA_W-1:0] oNEXT_DATA,
  output logic [P_TAG_W-1:0]  oNEXT_TAG,
  output logic                oNEXT_FAULT
);

  logic [P_DATA_W-1:0] in_data;
  logic                in_fault;
  logic                accept;
  logic                out_load;

  logic                skid_valid;
  logic [P_DATA_W-1:0] skid_data;
  logic [P_TAG_W-1:0]  skid_tag;
  logic                skid_fault;

  execute_load_extract #(.P_DATA_W(P_DATA_W)) u_extract (
    .mask      (iPREV_MASK),
    .is_signed (iPREV_SIGNED),
    .data      (iPREV_DATA),
    .result    (in_data),
    .fault     (in_fault)
  );

  // Lock is just the skid flag, so it never depends combinationally on iNEXT_LOCK.
  assign oPREV_LOCK = skid_valid;
  assign accept     = iPREV_VALID & ~skid_valid;
  assign out_load   = ~oNEXT_VALID | ~iNEXT_LOCK;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      oNEXT_VALID <= 1'b0;
      oNEXT_DATA  <= '0;
      oNEXT_TAG   <= '0;
      oNEXT_FAULT <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_tag    <= '0;
      skid_fault  <= 1'b0;
    end else if (iFLUSH) begin
      oNEXT_VALID <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (out_load) begin
      if (skid_valid) begin
        oNEXT_VALID <= 1'b1;
        oNEXT_DATA  <= skid_data;
        oNEXT_TAG   <= skid_tag;
        oNEXT_FAULT <= skid_fault;
        skid_valid  <= accept;
        if (accept) begin
          skid_data  <= in_data;
          skid_tag   <= iPREV_TAG;
          skid_fault <= in_fault;
        end
      end else if (accept) begin
        oNEXT_VALID <= 1'b1;
        oNEXT_DATA  <= in_data;
        oNEXT_TAG   <= iPREV_TAG;
        oNEXT_FAULT <= in_fault;
      end else begin
        oNEXT_VALID <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_tag   <= iPREV_TAG;
      skid_fault <= in_fault;
    end
  end

endmodule

// File: tb/tb_execute_load_align_pipe.sv
// tb/tb_execute_load_align_pipe.sv - directed and randomized checks of the load align stage
module tb_execute_load_align_pipe;
  import execute_load_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        pv, plock, psgn, nv, nlock, nfault;
  logic [3:0]  pmask;
  logic [4:0]  ptag, ntag;
  logic [31:0] pdata, ndata;

  logic        d_pv, d_plock, d_sgn, d_nv, d_nfault;
  logic [7:0]  d_mask;
  logic [4:0]  d_tag, d_ntag;
  logic [63:0] d_data, d_ndata;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
    logic        f;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  execute_load_align_pipe #(.P_DATA_W(32), .P_TAG_W(5)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush),
    .iPREV_VALID(pv), .oPREV_LOCK(plock), .iPREV_MASK(pmask), .iPREV_SIGNED(psgn),
    .iPREV_TAG(ptag), .iPREV_DATA(pdata),
    .oNEXT_VALID(nv), .iNEXT_LOCK(nlock), .oNEXT_DATA(ndata), .oNEXT_TAG(ntag), .oNEXT_FAULT(nfault)
  );

  execute_load_align_pipe #(.P_DATA_W(64), .P_TAG_W(5)) dut64 (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(1'b0),
    .iPREV_VALID(d_pv), .oPREV_LOCK(d_plock), .iPREV_MASK(d_mask), .iPREV_SIGNED(d_sgn),
    .iPREV_TAG(d_tag), .iPREV_DATA(d_data),
    .oNEXT_VALID(d_nv), .iNEXT_LOCK(1'b0), .oNEXT_DATA(d_ndata), .oNEXT_TAG(d_ntag), .oNEXT_FAULT(d_nfault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: collect selected bytes lane by lane, then extend; returns {fault, data}.
  function automatic logic [64:0] ref_align(input logic [7:0] mask, input logic sgn,
                                            input logic [63:0] data, input int lanes);
    int lo = -1;
    int n = 0;
    logic [63:0] v = '0;
    logic legal = 1'b0;
    for (int i = 0; i < lanes; i++)
      if (mask[i]) begin
        if (lo < 0) lo = i;
        n++;
      end
    if (n > 0 && (n & (n - 1)) == 0)
      if (lo % n == 0 && mask == 8'(((1 << n) - 1) << lo)) legal = 1'b1;
    if (!legal) return {1'b1, 64'h0};
    for (int i = lo; i < lo + n; i++)
      v = (v << 8) | 64'(data[(lanes - 1 - i) * 8 +: 8]);
    if (n < lanes && sgn && v[8 * n - 1])
      for (int b = 8 * n; b < lanes * 8; b++) v[b] = 1'b1;
    return {1'b0, v};
  endfunction

  task automatic drive(input logic v, input logic [3:0] m, input logic s, input logic [31:0] d, input logic [4:0] t);
    pv = v; pmask = m; psgn = s; pdata = d; ptag = t;
  endtask

  task automatic single(input string name, input logic [3:0] m, input logic s, input logic [31:0] d,
                        input logic [4:0] t, input logic [31:0] exp_d, input logic exp_f);
    logic [64:0] r;
    r = ref_align(8'(m), s, 64'(d), 4);
    nlock = 1'b0;
    drive(1'b1, m, s, d, t);
    @(negedge clk);
    pv = 1'b0;
    chk({name, "_valid"}, 64'(nv), 64'd1);
    chk({name, "_data"}, 64'(ndata), 64'(exp_d));
    chk({name, "_model"}, 64'(ndata), 64'(r[31:0]));
    chk({name, "_fault"}, 64'(nfault), 64'(exp_f));
    chk({name, "_tag"}, 64'(ntag), 64'(t));
    @(negedge clk);
  endtask

  initial begin
    logic [64:0] r;
    logic        held;
    logic [31:0] hd;
    logic [4:0]  ht;
    logic        hf;
    rst = 1'b1; flush = 1'b0; nlock = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 32'h0, 5'h0);
    d_pv = 1'b0; d_mask = 8'h0; d_sgn = 1'b0; d_tag = 5'h0; d_data = 64'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(nv), 64'd0);
    chk("rst_lock", 64'(plock), 64'd0);
    chk("rst_data", 64'(ndata), 64'd0);
    chk("rst_tag", 64'(ntag), 64'd0);
    chk("rst_fault", 64'(nfault), 64'd0);
    rst = 1'b0;

    single("byte_u", 4'b0001, 1'b0, 32'h88776655, 5'd3, 32'h00000088, 1'b0);
    single("byte_s", 4'b0001, 1'b1, 32'h88776655, 5'd4, 32'hFFFFFF88, 1'b0);
    single("half_s", 4'b1100, 1'b1, 32'h12348001, 5'd5, 32'hFFFF8001, 1'b0);
    single("half_u", 4'b0011, 1'b0, 32'h12348001, 5'd6, 32'h00001234, 1'b0);
    single("word_s", 4'b1111, 1'b1, 32'h92348001, 5'd7, 32'h92348001, 1'b0);
    single("ill_0110", 4'b0110, 1'b0, 32'h12345678, 5'd8, 32'h0, 1'b1);
    single("ill_0101", 4'b0101, 1'b1, 32'h12345678, 5'd9, 32'h0, 1'b1);
    single("ill_0000", 4'b0000, 1'b0, 32'h12345678, 5'd10, 32'h0, 1'b1);

    // 64-bit instance
    d_pv = 1'b1; d_mask = 8'hF0; d_sgn = 1'b1; d_data = 64'h0102030405060708; d_tag = 5'd11;
    @(negedge clk);
    chk("d64_f0_data", d_ndata, 64'h0000000005060708);
    chk("d64_f0_tag", 64'(d_ntag), 64'd11);
    for (int i = 0; i < 24; i++) begin
      d_mask = (i % 2 == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      if (i % 6 == 1) d_mask = 8'h0F << (4 * $urandom_range(0, 1));
      if (i % 6 == 3) d_mask = 8'h03 << (2 * $urandom_range(0, 3));
      d_sgn = 1'($urandom_range(0, 1));
      d_data = {$urandom, $urandom};
      d_tag = 5'(i);
      r = ref_align(d_mask, d_sgn, d_data, 8);
      @(negedge clk);
      chk("d64_rand_data", d_ndata, r[63:0]);
      chk("d64_rand_fault", 64'(d_nfault), 64'(r[64]));
    end
    d_pv = 1'b0;

    // backpressure: tags 1,2,3 against a held output
    nlock = 1'b1;
    drive(1'b1, 4'b1111, 1'b0, 32'hA1, 5'd1);
    @(negedge clk);
    drive(1'b1, 4'b1111, 1'b0, 32'hA2, 5'd2);
    @(negedge clk);
    drive(1'b1, 4'b1111, 1'b0, 32'hA3, 5'd3);
    chk("bp_out_tag", 64'(ntag), 64'd1);
    chk("bp_lock", 64'(plock), 64'd1);
    @(negedge clk);
    chk("bp_hold_tag", 64'(ntag), 64'd1);
    chk("bp_hold_data", 64'(ndata), 64'hA1);
    nlock = 1'b0;
    @(negedge clk);
    chk("bp_rel_tag2", 64'(ntag), 64'd2);
    chk("bp_rel_lock", 64'(plock), 64'd0);
    @(negedge clk);
    pv = 1'b0;
    chk("bp_tag3", 64'(ntag), 64'd3);
    chk("bp_tag3_valid", 64'(nv), 64'd1);
    @(negedge clk);
    chk("bp_drained", 64'(nv), 64'd0);

    // flush with both entries full plus a valid input
    nlock = 1'b1;
    drive(1'b1, 4'b1111, 1'b0, 32'hB1, 5'd21);
    @(negedge clk);
    drive(1'b1, 4'b1111, 1'b0, 32'hB2, 5'd22);
    @(negedge clk);
    drive(1'b1, 4'b1111, 1'b0, 32'hB3, 5'd23);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; pv = 1'b0;
    chk("fl_valid", 64'(nv), 64'd0);
    chk("fl_lock", 64'(plock), 64'd0);
    nlock = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fl_no_ghost", 64'(nv), 64'd0);
    end

    // reset mid-stream
    drive(1'b1, 4'b0011, 1'b0, 32'h5566_7788, 5'd12);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4'b1111, 1'b0, 32'hDEAD_BEEF, 5'd13);
    @(negedge clk);
    rst = 1'b0;
    chk("mr_valid", 64'(nv), 64'd0);
    chk("mr_lock", 64'(plock), 64'd0);
    chk("mr_data", 64'(ndata), 64'd0);
    chk("mr_tag", 64'(ntag), 64'd0);
    drive(1'b1, 4'b0100, 1'b1, 32'h0011_F233, 5'd14);
    @(negedge clk);
    pv = 1'b0;
    chk("mr_new_valid", 64'(nv), 64'd1);
    chk("mr_new_data", 64'(ndata), 64'hFFFF_FFF2);
    chk("mr_new_tag", 64'(ntag), 64'd14);
    @(negedge clk);

    // randomized stream against a FIFO reference
    held = 1'b0; hd = '0; ht = '0; hf = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (held) begin
        chk("rnd_hold_data", 64'(ndata), 64'(hd));
        chk("rnd_hold_tag", 64'(ntag), 64'(ht));
        chk("rnd_hold_fault", 64'(nfault), 64'(hf));
      end
      nlock = ($urandom_range(0, 2) == 0);
      if (nv && !nlock) begin
        if (q.size() == 0) chk("rnd_unexpected", 64'd1, 64'd0);
        else begin
          chk("rnd_data", 64'(ndata), 64'(q[0].d));
          chk("rnd_tag", 64'(ntag), 64'(q[0].t));
          chk("rnd_fault", 64'(nfault), 64'(q[0].f));
          void'(q.pop_front());
        end
      end
      held = nv && nlock;
      hd = ndata; ht = ntag; hf = nfault;
      pmask = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      drive(1'($urandom_range(0, 1)), pmask, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)));
      if (pv && !plock) begin
        r = ref_align(8'(pmask), psgn, 64'(pdata), 4);
        q.push_back('{d: r[31:0], t: ptag, f: r[64]});
      end
      @(negedge clk);
    end
    pv = 1'b0; nlock = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      if (nv) begin
        chk("drain_data", 64'(ndata), 64'(q[0].d));
        chk("drain_tag", 64'(ntag), 64'(q[0].t));
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
